// File: rtl/simd_mac_fu_pkg.sv
// Shared types and helpers for the SIMD dot-product MAC functional unit.
// Op encodings, pipeline depth and lane-count helper.
package simd_mac_fu_pkg;

  typedef enum logic [1:0] {
    MAC_INIT = 2'd0,
    MAC_ACC  = 2'd1,
    MAC_READ = 2'd2,
    MAC_CLR  = 2'd3
  } mac_op_e;

  localparam int SIMD_MAC_LATENCY = 2;

  function automatic int simd_mac_lanes(input int xlen, input int elem_w);
    return xlen / elem_w;
  endfunction

endpackage

// File: rtl/simd_mac_fu_lane_mult.sv
// One SIMD lane: extends each element by one bit according to its signedness
// and forms the signed (2*ELEM_W+2)-bit product.
module simd_mac_fu_lane_mult
  import simd_mac_fu_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0]   a_i,
  input  logic [ELEM_W-1:0]   b_i,
  input  logic                a_signed_i,
  input  logic                b_signed_i,
  output logic [2*ELEM_W+1:0] prod_o
);

  localparam int PROD_W = 2 * ELEM_W + 2;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;

  // Widening both operands to the product width keeps the multiply full-precision.
  assign a_ext  = PROD_W'($signed({a_signed_i & a_i[ELEM_W-1], a_i}));
  assign b_ext  = PROD_W'($signed({b_signed_i & b_i[ELEM_W-1], b_i}));
  assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/simd_mac_fu.sv
// Pipelined SIMD dot-product MAC: stage 1 registers lane products, stage 2
// reduces them and updates one of NUM_ACC accumulators with optional saturation.
module simd_mac_fu
  import simd_mac_fu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ELEM_W        = 8,
  parameter int NUM_ACC       = 4,
  parameter int ACC_W         = 32,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        valid_i,
  output logic                                        ready_o,
  input  logic                                        flush_i,
  input  mac_op_e                                     op_i,
  input  logic [((NUM_ACC > 1) ? $clog2(NUM_ACC) : 1)-1:0] acc_sel_i,
  input  logic                                        a_signed_i,
  input  logic                                        b_signed_i,
  input  logic                                        sat_i,
  input  logic [XLEN-1:0]                             operand_a_i,
  input  logic [XLEN-1:0]                             operand_b_i,
  input  logic [TRANS_ID_BITS-1:0]                    trans_id_i,
  output logic [XLEN-1:0]                             result_o,
  output logic                                        overflow_o,
  output logic                                        valid_o,
  output logic [TRANS_ID_BITS-1:0]                    trans_id_o
);

  localparam int LANES  = simd_mac_lanes(XLEN, ELEM_W);
  localparam int PROD_W = 2 * ELEM_W + 2;
  localparam int SUM_W  = ACC_W + 1;
  localparam int SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int TREE_N = 2 ** $clog2(LANES);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic accept;
  assign ready_o = ~flush_i & ~rst_i;
  assign accept  = valid_i & ready_o;

  // ---------------- Stage 1: lane multipliers ----------------
  logic [PROD_W-1:0] prod_lane [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      simd_mac_fu_lane_mult #(.ELEM_W(ELEM_W)) u_lane_mult (
        .a_i        (operand_a_i[gi*ELEM_W +: ELEM_W]),
        .b_i        (operand_b_i[gi*ELEM_W +: ELEM_W]),
        .a_signed_i (a_signed_i),
        .b_signed_i (b_signed_i),
        .prod_o     (prod_lane[gi])
      );
    end
  endgenerate

  logic                     s1_valid_q, s1_valid_d;
  mac_op_e                  s1_op_q, s1_op_d;
  logic [SEL_W-1:0]         s1_sel_q, s1_sel_d;
  logic                     s1_sat_q, s1_sat_d;
  logic [TRANS_ID_BITS-1:0] s1_tid_q, s1_tid_d;
  logic [ACC_W-1:0]         s1_init_q, s1_init_d;
  logic [PROD_W-1:0]        s1_prod_q [LANES];
  logic [PROD_W-1:0]        s1_prod_d [LANES];

  // Payload registers only load on accept so they stay quiet when idle.
  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = s1_op_q;
    s1_sel_d   = s1_sel_q;
    s1_sat_d   = s1_sat_q;
    s1_tid_d   = s1_tid_q;
    s1_init_d  = s1_init_q;
    s1_prod_d  = s1_prod_q;
    if (accept) begin
      s1_op_d   = op_i;
      s1_sel_d  = acc_sel_i;
      s1_sat_d  = sat_i;
      s1_tid_d  = trans_id_i;
      s1_init_d = operand_a_i[ACC_W-1:0];
      s1_prod_d = prod_lane;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= MAC_INIT;
      s1_sel_q   <= '0;
      s1_sat_q   <= 1'b0;
      s1_tid_q   <= '0;
      s1_init_q  <= '0;
      for (int l = 0; l < LANES; l++) s1_prod_q[l] <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_sel_q   <= s1_sel_d;
      s1_sat_q   <= s1_sat_d;
      s1_tid_q   <= s1_tid_d;
      s1_init_q  <= s1_init_d;
      s1_prod_q  <= s1_prod_d;
    end
  end

  // ---------------- Stage 2: reduction and accumulate ----------------
  logic signed [SUM_W-1:0] dot;

  // Heap-ordered binary tree, padded with zero leaves up to a power of two.
  always_comb begin : p_adder_tree
    logic signed [SUM_W-1:0] node [2*TREE_N-1];
    for (int n = 0; n < TREE_N; n++) begin
      if (n < LANES) node[TREE_N-1+n] = SUM_W'($signed(s1_prod_q[n]));
      else           node[TREE_N-1+n] = '0;
    end
    for (int n = TREE_N - 2; n >= 0; n--) begin
      node[n] = node[2*n+1] + node[2*n+2];
    end
    dot = node[0];
  end

  logic [ACC_W-1:0]         acc_q [NUM_ACC];
  logic [ACC_W-1:0]         acc_d [NUM_ACC];
  logic [NUM_ACC-1:0]       ovf_q, ovf_d;
  logic                     valid_q, valid_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     overflow_q, overflow_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;

  logic [SEL_W-1:0]        acc_idx;
  logic [ACC_W-1:0]        acc_cur;
  logic signed [SUM_W-1:0] acc_sum;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        new_acc;
  logic                    new_ovf;
  logic                    live;

  assign acc_idx = (NUM_ACC == 1) ? '0 : s1_sel_q;
  assign acc_cur = acc_q[acc_idx];
  assign acc_sum = SUM_W'($signed(acc_cur)) + dot;
  // Leaving the signed ACC_W range shows up as the top two bits disagreeing.
  assign sum_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
  assign live    = s1_valid_q & ~flush_i;

  always_comb begin
    new_acc = acc_cur;
    new_ovf = ovf_q[acc_idx];
    case (s1_op_q)
      MAC_INIT: begin
        new_acc = s1_init_q;
        new_ovf = 1'b0;
      end
      MAC_ACC: begin
        if (sum_ovf && s1_sat_q) new_acc = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        else                     new_acc = acc_sum[ACC_W-1:0];
        new_ovf = ovf_q[acc_idx] | sum_ovf;
      end
      MAC_CLR: begin
        new_acc = '0;
        new_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    valid_d    = live;
    result_d   = result_q;
    overflow_d = overflow_q;
    tid_d      = tid_q;
    if (live) begin
      acc_d[acc_idx] = new_acc;
      ovf_d[acc_idx] = new_ovf;
      result_d       = XLEN'($signed(new_acc));
      overflow_d     = new_ovf;
      tid_d          = s1_tid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      ovf_q      <= '0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      tid_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      tid_q      <= tid_d;
    end
  end

  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign overflow_o = overflow_q;
  assign trans_id_o = tid_q;

endmodule

// File: tb/tb_simd_mac_fu.sv
// Directed bench for simd_mac_fu: an arithmetic reference model checked every
// cycle, plus hand-computed results for the headline scenarios.
module tb_simd_mac_fu;
  import simd_mac_fu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  mac_op_e     op_i = MAC_READ;
  logic [1:0]  acc_sel_i = '0;
  logic        a_signed_i = 1'b0;
  logic        b_signed_i = 1'b0;
  logic        sat_i = 1'b0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic [2:0]  trans_id_i = '0;
  logic [31:0] result_o;
  logic        overflow_o;
  logic        valid_o;
  logic [2:0]  trans_id_o;

  simd_mac_fu dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .op_i(op_i), .acc_sel_i(acc_sel_i),
    .a_signed_i(a_signed_i), .b_signed_i(b_signed_i), .sat_i(sat_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .trans_id_i(trans_id_i), .result_o(result_o), .overflow_o(overflow_o),
    .valid_o(valid_o), .trans_id_o(trans_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [2:0]  tid;
    logic [31:0] res;
    logic        ovf;
    string       name;
  } lit_t;
  lit_t lit_q[$];

  // Reference model state.
  longint     m_acc [4];
  bit         m_flag [4];
  bit         m_valid = 0;
  logic [31:0] m_result = '0;
  bit         m_ovf = 0;
  logic [2:0] m_tid = '0;
  bit         started = 0;
  bit         p_v = 0;
  mac_op_e    p_op;
  int         p_sel;
  logic [31:0] p_a, p_b;
  bit         p_as, p_bs, p_sat;
  logic [2:0] p_tid;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  function automatic longint dot4(input logic [31:0] a, input logic [31:0] b,
                                  input bit as, input bit bs);
    longint s = 0;
    for (int l = 0; l < 4; l++) begin
      logic [7:0] ab, bb;
      longint av, bv;
      ab = a[8*l +: 8];
      bb = b[8*l +: 8];
      av = as ? longint'($signed(ab)) : longint'(ab);
      bv = bs ? longint'($signed(bb)) : longint'(bb);
      s += av * bv;
    end
    return s;
  endfunction

  always @(negedge clk_i) begin
    if (started) begin
      chk("ready_o", {31'd0, ready_o}, {31'd0, (!flush_i && !rst_i)});
      chk("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
      chk("result_o", result_o, m_result);
      chk("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
      chk("trans_id_o", {29'd0, trans_id_o}, {29'd0, m_tid});
      if (valid_o === 1'b1 && lit_q.size() > 0 && lit_q[0].tid === trans_id_o) begin
        chk({lit_q[0].name, "_result"}, result_o, lit_q[0].res);
        chk({lit_q[0].name, "_ovf"}, {31'd0, overflow_o}, {31'd0, lit_q[0].ovf});
        void'(lit_q.pop_front());
      end
    end
    // Effect of the coming rising edge.
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_flag[i] = 0; end
      m_valid = 0; m_result = '0; m_ovf = 0; m_tid = '0; p_v = 0;
      started = 1;
    end else begin
      m_valid = 0;
      if (p_v && !flush_i) begin
        longint s;
        case (p_op)
          MAC_INIT: begin m_acc[p_sel] = longint'($signed(p_a)); m_flag[p_sel] = 0; end
          MAC_ACC: begin
            s = m_acc[p_sel] + dot4(p_a, p_b, p_as, p_bs);
            if (s > AMAX) begin
              m_flag[p_sel] = 1;
              s = p_sat ? AMAX : s - 64'sd4294967296;
            end else if (s < AMIN) begin
              m_flag[p_sel] = 1;
              s = p_sat ? AMIN : s + 64'sd4294967296;
            end
            m_acc[p_sel] = s;
          end
          MAC_CLR: begin m_acc[p_sel] = 0; m_flag[p_sel] = 0; end
          default: ;
        endcase
        m_valid  = 1;
        m_result = m_acc[p_sel][31:0];
        m_ovf    = m_flag[p_sel];
        m_tid    = p_tid;
      end
      p_v = valid_i && !flush_i;
      p_op = op_i; p_sel = int'(acc_sel_i); p_a = operand_a_i; p_b = operand_b_i;
      p_as = a_signed_i; p_bs = b_signed_i; p_sat = sat_i; p_tid = trans_id_i;
    end
  end

  logic [2:0] next_tid = '0;

  task automatic set_op(input mac_op_e op, input int sel, input logic [31:0] a,
                        input logic [31:0] b, input bit as, input bit bs, input bit sat);
    valid_i = 1'b1; op_i = op; acc_sel_i = 2'(sel);
    operand_a_i = a; operand_b_i = b;
    a_signed_i = as; b_signed_i = bs; sat_i = sat;
    trans_id_i = next_tid;
    next_tid++;
  endtask

  task automatic issue(input mac_op_e op, input int sel, input logic [31:0] a,
                       input logic [31:0] b, input bit as, input bit bs, input bit sat,
                       input bit lit, input logic [31:0] lres, input bit lovf,
                       input string name);
    if (lit) lit_q.push_back('{tid: next_tid, res: lres, ovf: lovf, name: name});
    set_op(op, sel, a, b, as, bs, sat);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(2);
    rst_i = 1'b0;
    idle(1);

    // Basic init then accumulate: 5 + (1+2+3+4) = 15.
    issue(MAC_INIT, 0, 32'd5, 32'd0, 0, 0, 0, 1, 32'd5, 0, "t1_init");
    issue(MAC_ACC, 0, 32'h01020304, 32'h01010101, 1, 0, 0, 1, 32'd15, 0, "t1_acc");
    idle(3);

    // Signed -1 times unsigned 255.
    issue(MAC_CLR, 1, 32'hDEADBEEF, 32'd0, 0, 0, 0, 1, 32'd0, 0, "t2_clr");
    issue(MAC_ACC, 1, 32'h000000FF, 32'h000000FF, 1, 0, 0, 1, 32'hFFFFFF01, 0, "t2_acc");
    idle(3);

    // Positive overflow, saturating then wrapping.
    issue(MAC_INIT, 2, 32'h7FFFFFF0, 32'd0, 0, 0, 0, 0, '0, 0, "");
    issue(MAC_ACC, 2, 32'h7F7F7F7F, 32'hFFFFFFFF, 1, 0, 1, 1, 32'h7FFFFFFF, 1, "t3_sat");
    issue(MAC_INIT, 2, 32'h7FFFFFF0, 32'd0, 0, 0, 0, 1, 32'h7FFFFFF0, 0, "t3_reinit");
    issue(MAC_ACC, 2, 32'h7F7F7F7F, 32'hFFFFFFFF, 1, 0, 0, 1, 32'h8001F9F4, 1, "t3_wrap");
    issue(MAC_READ, 2, 32'd0, 32'd0, 0, 0, 0, 1, 32'h8001F9F4, 1, "t3_read");
    idle(3);

    // Back-to-back dependent accumulates.
    issue(MAC_INIT, 0, 32'd0, 32'd0, 0, 0, 0, 0, '0, 0, "");
    issue(MAC_ACC, 0, 32'h01020304, 32'h01010101, 1, 0, 0, 1, 32'd10, 0, "t4_a");
    issue(MAC_ACC, 0, 32'h01020304, 32'h01010101, 1, 0, 0, 1, 32'd20, 0, "t4_b");
    issue(MAC_ACC, 0, 32'h01020304, 32'h01010101, 1, 0, 0, 1, 32'd30, 0, "t4_c");
    idle(3);

    // Flush kills the op in stage 2 and the request presented with it.
    issue(MAC_INIT, 3, 32'd100, 32'd0, 0, 0, 0, 0, '0, 0, "");
    idle(2);
    issue(MAC_ACC, 3, 32'h01020304, 32'h01010101, 1, 0, 0, 1, 32'd110, 0, "t5_kept");
    issue(MAC_ACC, 3, 32'h01020304, 32'h01010101, 1, 0, 0, 0, '0, 0, "");
    set_op(MAC_CLR, 3, 32'd0, 32'd0, 0, 0, 0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    idle(2);
    issue(MAC_READ, 3, 32'd0, 32'd0, 0, 0, 0, 1, 32'd110, 0, "t5_read");
    idle(3);

    // Reset with an accumulate in flight clears everything.
    issue(MAC_ACC, 2, 32'h01020304, 32'h01010101, 1, 0, 0, 0, '0, 0, "");
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++)
      issue(MAC_READ, i, 32'd0, 32'd0, 0, 0, 0, 1, 32'd0, 0, $sformatf("t6_read%0d", i));
    idle(4);

    chk("lit_drain", lit_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
